ovi_vpu_responder: RTL and testbench

//  VPU-side end of the OVI link: a cycle-accurate responder model standing in for the vector unit.

---
 rtl/ovi_vpu_responder.sv | 168 ++++++++++++++++
 tb/tb_ovi_vpu_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_vpu_responder.sv
`default_nettype none
// ovi_vpu_responder: VPU-side OVI peer - issue/dispatch handshake, store packet stream, completion.
// Rev 1.0
module ovi_vpu_responder #(
   parameter int EXEC_LAT      = 4,
   parameter int MEMDATA_WIDTH = 512,
   parameter int SBID_WIDTH    = 5,
   parameter int VL_WIDTH      = 14,
   parameter int STORE_CREDITS = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_issue_valid,
   input  logic [31:0]              i_issue_instr,
   input  logic [SBID_WIDTH-1:0]    i_issue_sbid,
   input  logic [VL_WIDTH-1:0]      i_issue_vl,
   input  logic [1:0]               i_issue_sew,
   output logic                     o_issue_credit,
   input  logic                     i_dispatch_next_senior,
   input  logic                     i_dispatch_kill,
   input  logic [SBID_WIDTH-1:0]    i_dispatch_sbid,
   output logic                     o_sync_start,
   output logic                     o_store_valid,
   output logic [MEMDATA_WIDTH-1:0] o_store_data,
   input  logic                     i_store_credit,
   input  logic                     i_memop_sync_end,
   input  logic [SBID_WIDTH-1:0]    i_memop_sbid,
   output logic                     o_completed_valid,
   output logic [SBID_WIDTH-1:0]    o_completed_sbid,
   output logic [63:0]              o_completed_dest_reg,
   output logic                     o_proto_err
);
   localparam int          NPKT_W    = VL_WIDTH + 7;
   localparam int          LAT_W     = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
   localparam logic [6:0]  OPC_STORE = 7'b0100111;
   localparam logic [4:0]  CNT_MAX   = 5'd31;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_DISP, S_EXEC, S_STORE_TX, S_WAIT_END, S_COMPLETE
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [31:0]         r_instr;
   logic [SBID_WIDTH-1:0] r_sbid;
   logic [NPKT_W-1:0]   r_npkt, r_pkt_idx;
   logic [4:0]          r_store_cnt;
   logic [LAT_W-1:0]    r_lat_cnt;
   logic                r_issue_credit, r_sync_start, r_completed_valid, r_proto_err;
   logic [SBID_WIDTH-1:0] r_completed_sbid;
   logic [63:0]         r_dest_reg;

   logic                w_kill_hit, w_issue_take, w_is_store, w_store_valid, w_proto_viol;
   logic                w_enter_complete, w_enter_exec;
   logic [63:0]         w_bits, w_npkt64;
   logic                w_unused_npkt_hi;
   logic [31:0]         w_word;

   // Packet count needs 64-bit headroom; only the low NPKT_W bits can be non-zero.
   assign w_bits           = 64'(i_issue_vl) << ({1'b0, i_issue_sew} + 3'd3);
   assign w_npkt64         = (w_bits + 64'(MEMDATA_WIDTH - 1)) / 64'(MEMDATA_WIDTH);
   assign w_unused_npkt_hi = |w_npkt64[63:NPKT_W];

   assign w_issue_take  = (r_state == S_IDLE) && i_issue_valid;
   assign w_is_store    = (r_instr[6:0] == OPC_STORE);
   assign w_store_valid = (r_state == S_STORE_TX) && !r_sync_start &&
                          (r_store_cnt != 5'd0) && (r_pkt_idx < r_npkt);
   assign w_word        = {16'(r_sbid), 16'(r_pkt_idx)};

   assign w_proto_viol = (i_issue_valid && (r_state != S_IDLE)) ||
                         (i_memop_sync_end && ((r_state != S_WAIT_END) || (i_memop_sbid != r_sbid))) ||
                         (i_store_credit && !w_store_valid && (r_store_cnt == CNT_MAX));

   always_comb begin
      w_state_nxt = r_state;
      w_kill_hit  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_issue_valid)
               w_state_nxt = (i_dispatch_next_senior && (i_dispatch_sbid == i_issue_sbid)) ? S_EXEC : S_WAIT_DISP;
         end
         S_WAIT_DISP: begin
            if (i_dispatch_kill && (i_dispatch_sbid == r_sbid)) begin
               w_state_nxt = S_IDLE;
               w_kill_hit  = 1'b1;
            end else if (i_dispatch_next_senior && (i_dispatch_sbid == r_sbid)) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_lat_cnt == '0)
               w_state_nxt = w_is_store ? S_STORE_TX : S_COMPLETE;
         end
         S_STORE_TX: begin
            if (r_pkt_idx == r_npkt)
               w_state_nxt = S_WAIT_END;
         end
         S_WAIT_END: begin
            if (i_memop_sync_end && (i_memop_sbid == r_sbid))
               w_state_nxt = S_COMPLETE;
         end
         S_COMPLETE: w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   assign w_enter_complete = (w_state_nxt == S_COMPLETE);
   assign w_enter_exec     = (w_state_nxt == S_EXEC) && (r_state != S_EXEC);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_instr           <= '0;
         r_sbid            <= '0;
         r_npkt            <= '0;
         r_pkt_idx         <= '0;
         r_store_cnt       <= 5'(STORE_CREDITS);
         r_lat_cnt         <= '0;
         r_issue_credit    <= 1'b0;
         r_sync_start      <= 1'b0;
         r_completed_valid <= 1'b0;
         r_completed_sbid  <= '0;
         r_dest_reg        <= '0;
         r_proto_err       <= 1'b0;
      end else begin
         if (w_issue_take) begin
            r_instr   <= i_issue_instr;
            r_sbid    <= i_issue_sbid;
            r_npkt    <= w_npkt64[NPKT_W-1:0];
            r_pkt_idx <= '0;
         end else if (w_store_valid) begin
            r_pkt_idx <= r_pkt_idx + NPKT_W'(1);
         end

         if (w_enter_exec)
            r_lat_cnt <= LAT_W'(EXEC_LAT - 1);
         else if ((r_state == S_EXEC) && (r_lat_cnt != '0))
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);

         // A credit arriving with a packet cancels out; excess credits saturate.
         case ({w_store_valid, i_store_credit})
            2'b10:   r_store_cnt <= r_store_cnt - 5'd1;
            2'b01:   r_store_cnt <= (r_store_cnt == CNT_MAX) ? CNT_MAX : r_store_cnt + 5'd1;
            default: r_store_cnt <= r_store_cnt;
         endcase

         r_issue_credit    <= w_enter_complete || w_kill_hit;
         r_sync_start      <= (r_state == S_EXEC) && (r_lat_cnt == '0) && w_is_store;
         r_completed_valid <= w_enter_complete;
         r_completed_sbid  <= w_enter_complete ? r_sbid : '0;
         r_dest_reg        <= w_enter_complete ? {32'h0, r_instr} : 64'h0;
         r_proto_err       <= r_proto_err || w_proto_viol;
      end
   end

   assign o_issue_credit       = r_issue_credit;
   assign o_sync_start         = r_sync_start;
   assign o_store_valid        = w_store_valid;
   assign o_store_data         = w_store_valid ? {(MEMDATA_WIDTH/32){w_word}} : '0;
   assign o_completed_valid    = r_completed_valid;
   assign o_completed_sbid     = r_completed_sbid;
   assign o_completed_dest_reg = r_dest_reg;
   assign o_proto_err          = r_proto_err;
endmodule
`default_nettype wire

// File: tb/tb_ovi_vpu_responder.sv
`default_nettype none
// tb_ovi_vpu_responder: randomized scoreboard bench with a transaction-level reference model.
module tb_ovi_vpu_responder;
   localparam int EXEC_LAT = 4;
   localparam int MW       = 512;
   localparam int SW       = 5;
   localparam int VW       = 14;
   localparam int SC       = 1;
   localparam logic [6:0] OPC_STORE = 7'b0100111;

   logic clk = 1'b0;
   logic rst;
   logic i_issue_valid, i_dispatch_next_senior, i_dispatch_kill, i_store_credit, i_memop_sync_end;
   logic [31:0] i_issue_instr;
   logic [SW-1:0] i_issue_sbid, i_dispatch_sbid, i_memop_sbid;
   logic [VW-1:0] i_issue_vl;
   logic [1:0] i_issue_sew;
   logic o_issue_credit, o_sync_start, o_store_valid, o_completed_valid, o_proto_err;
   logic [MW-1:0] o_store_data;
   logic [SW-1:0] o_completed_sbid;
   logic [63:0] o_completed_dest_reg;

   ovi_vpu_responder #(.EXEC_LAT(EXEC_LAT), .MEMDATA_WIDTH(MW), .SBID_WIDTH(SW),
                       .VL_WIDTH(VW), .STORE_CREDITS(SC)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_issue_valid(i_issue_valid), .i_issue_instr(i_issue_instr), .i_issue_sbid(i_issue_sbid),
      .i_issue_vl(i_issue_vl), .i_issue_sew(i_issue_sew), .o_issue_credit(o_issue_credit),
      .i_dispatch_next_senior(i_dispatch_next_senior), .i_dispatch_kill(i_dispatch_kill),
      .i_dispatch_sbid(i_dispatch_sbid), .o_sync_start(o_sync_start),
      .o_store_valid(o_store_valid), .o_store_data(o_store_data), .i_store_credit(i_store_credit),
      .i_memop_sync_end(i_memop_sync_end), .i_memop_sbid(i_memop_sbid),
      .o_completed_valid(o_completed_valid), .o_completed_sbid(o_completed_sbid),
      .o_completed_dest_reg(o_completed_dest_reg), .o_proto_err(o_proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [SW-1:0] sbid; logic [63:0] dest; } comp_t;
   comp_t         comp_q[$];
   int            sync_q[$];
   logic [MW-1:0] pkt_q[$];
   int            kill_q[$];
   int            due_q[$];
   comp_t         mon_e;
   int            credit_delay = 0;
   int            vpu_credits  = SC;
   bit            sync_seen    = 1'b0;
   int            sync_seen_cyc = 0;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      comp_q.delete(); sync_q.delete(); pkt_q.delete(); kill_q.delete(); due_q.delete();
      vpu_credits = SC;
      sync_seen = 1'b0;
      i_issue_valid = 0; i_dispatch_next_senior = 0; i_dispatch_kill = 0;
      i_store_credit = 0; i_memop_sync_end = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_model();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic timeout(input string what);
      checks++;
      errors++;
      $display("FAIL timeout_%s: got pending transactions, expected drained", what);
      apply_reset();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_issue_credit"}, MW'(o_issue_credit), '0);
      chk({tag, "_sync_start"}, MW'(o_sync_start), '0);
      chk({tag, "_store_valid"}, MW'(o_store_valid), '0);
      chk({tag, "_store_data"}, o_store_data, '0);
      chk({tag, "_completed_valid"}, MW'(o_completed_valid), '0);
      chk({tag, "_completed_sbid"}, MW'(o_completed_sbid), '0);
      chk({tag, "_dest_reg"}, MW'(o_completed_dest_reg), '0);
      chk({tag, "_proto_err"}, MW'(o_proto_err), '0);
   endtask

   task automatic wait_drain(input string what);
      int n = 0;
      while ((comp_q.size() != 0 || kill_q.size() != 0 || pkt_q.size() != 0 || sync_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) timeout(what);
   endtask

   // Monitor: pops expectations whenever the DUT presents an output; also plays the core's store-credit return.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            i_store_credit = 1'b0;
            continue;
         end
         if (o_sync_start) begin
            if (sync_q.size() == 0) chk("unexpected_sync_start", 1, 0);
            else                    chk("sync_start_cycle", MW'(cyc), MW'(sync_q.pop_front()));
            sync_seen = 1'b1;
            sync_seen_cyc = cyc;
         end
         if (o_store_valid) begin
            chk("pkt_after_sync", MW'(sync_seen && (cyc > sync_seen_cyc)), 1);
            chk("pkt_with_credit", MW'(vpu_credits > 0), 1);
            vpu_credits--;
            if (pkt_q.size() == 0) chk("unexpected_pkt", 1, 0);
            else                   chk("pkt_data", o_store_data, pkt_q.pop_front());
            due_q.push_back(cyc + credit_delay);
         end
         i_store_credit = 1'b0;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            i_store_credit = 1'b1;
            vpu_credits++;
         end
         if (o_completed_valid) begin
            if (comp_q.size() == 0) chk("unexpected_completion", 1, 0);
            else begin
               mon_e = comp_q.pop_front();
               chk("completion_cycle", MW'(cyc), MW'(mon_e.cyc));
               chk("completion_sbid", MW'(o_completed_sbid), MW'(mon_e.sbid));
               chk("completion_dest", MW'(o_completed_dest_reg), MW'(mon_e.dest));
               chk("credit_with_completion", MW'(o_issue_credit), 1);
            end
         end else if (o_issue_credit) begin
            if (kill_q.size() == 0) chk("unexpected_issue_credit", 1, 0);
            else                    chk("kill_credit_cycle", MW'(cyc), MW'(kill_q.pop_front()));
         end
      end
   end

   task automatic run_op(input logic [31:0] instr, input logic [SW-1:0] sbid, input int vl, input int sew,
                         input int sdly, input bit kill, input bit kill_sen, input int cdly,
                         input int edly, input bit abort);
      int s_cyc, npkt, bits, n;
      bit is_store;
      comp_t e;
      logic [31:0] w;
      is_store = (instr[6:0] == OPC_STORE);
      if (kill && sdly == 0) sdly = 1;
      credit_delay = cdly;
      sync_seen = 1'b0;
      tick();
      i_issue_valid = 1; i_issue_instr = instr; i_issue_sbid = sbid;
      i_issue_vl = VW'(vl); i_issue_sew = 2'(sew);
      i_dispatch_next_senior = 1;
      i_dispatch_sbid = (sdly == 0) ? sbid : (sbid ^ SW'(1));
      s_cyc = cyc;
      if (sdly != 0) begin
         tick();
         i_issue_valid = 0; i_dispatch_next_senior = 0;
         repeat (sdly - 1) tick();
         i_dispatch_sbid = sbid;
         s_cyc = cyc;
         if (kill) begin
            i_dispatch_kill = 1;
            i_dispatch_next_senior = kill_sen;
            kill_q.push_back(cyc + 1);
         end else begin
            i_dispatch_next_senior = 1;
         end
      end
      npkt = 0;
      if (!kill) begin
         if (is_store) begin
            sync_q.push_back(s_cyc + EXEC_LAT + 1);
            bits = vl * (8 << sew);
            npkt = (bits + MW - 1) / MW;
            for (int i = 0; i < npkt; i++) begin
               w = {16'(sbid), 16'(i)};
               pkt_q.push_back({(MW/32){w}});
            end
         end else begin
            e.cyc = s_cyc + EXEC_LAT + 1; e.sbid = sbid; e.dest = {32'h0, instr};
            comp_q.push_back(e);
         end
      end
      tick();
      i_issue_valid = 0; i_dispatch_next_senior = 0; i_dispatch_kill = 0;
      if (kill || !is_store) begin
         wait_drain(kill ? "kill" : "alu");
         return;
      end
      n = 0;
      if (abort) begin
         while (pkt_q.size() == npkt && n < 3000) begin tick(); n++; end
         if (n >= 3000) begin timeout("abort_wait"); return; end
         @(negedge clk);
         #2;
         rst = 1'b1;
         #1;
         check_outputs_zero("async_rst");
         clear_model();
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         return;
      end
      while (!(sync_seen && pkt_q.size() == 0) && n < 3000) begin tick(); n++; end
      if (n >= 3000) begin timeout("store_tx"); return; end
      repeat (3 + edly) tick();
      i_memop_sync_end = 1; i_memop_sbid = sbid;
      e.cyc = cyc + 1; e.sbid = sbid; e.dest = {32'h0, instr};
      comp_q.push_back(e);
      tick();
      i_memop_sync_end = 0;
      wait_drain("store");
   endtask

   logic [31:0] r_instr;
   int kind;

   initial begin
      rst = 1'b1;
      clear_model();
      i_issue_instr = 0; i_issue_sbid = 0; i_issue_vl = 0; i_issue_sew = 0;
      i_dispatch_sbid = 0; i_memop_sbid = 0;
      #1;
      check_outputs_zero("reset");
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_outputs_zero("post_reset");

      run_op({25'h0ABCDE, 7'b1010111}, 5'd3, 8, 2, 0, 0, 0, 0, 0, 0);
      run_op({25'h0012345, OPC_STORE}, 5'd5, 16, 3, 0, 0, 0, 0, 0, 0);
      run_op({25'h1FFFFFF, OPC_STORE}, 5'd9, 32, 3, 0, 0, 0, 3, 1, 0);
      run_op({25'h0000001, OPC_STORE}, 5'd11, 0, 1, 1, 0, 0, 0, 0, 0);
      chk("proto_err_vl0", MW'(o_proto_err), 0);
      run_op({25'h0000777, 7'b1010111}, 5'd7, 4, 0, 2, 1, 1, 0, 0, 0);
      run_op({25'h0000888, 7'b0000111}, 5'd8, 4, 0, 0, 0, 0, 0, 0, 0);
      run_op({25'h0000999, OPC_STORE}, 5'd12, 64, 3, 0, 0, 0, 3, 0, 1);
      run_op({25'h0000AAA, OPC_STORE}, 5'd13, 24, 3, 0, 0, 0, 3, 0, 0);
      chk("proto_err_directed", MW'(o_proto_err), 0);

      for (int k = 0; k < 30; k++) begin
         kind = $urandom_range(0, 9);
         r_instr = $urandom();
         if (kind < 4) r_instr[6:0] = OPC_STORE;
         else          r_instr[6:0] = ($urandom_range(0, 1) != 0) ? 7'b1010111 : 7'b0000111;
         run_op(r_instr, SW'($urandom_range(0, 31)), $urandom_range(0, 100), $urandom_range(0, 3),
                $urandom_range(0, 3), kind >= 8, $urandom_range(0, 1) != 0,
                $urandom_range(0, 3), $urandom_range(0, 2), 0);
         chk("proto_err_random", MW'(o_proto_err), 0);
      end

      tick();
      i_memop_sync_end = 1; i_memop_sbid = 0;
      tick();
      i_memop_sync_end = 0;
      tick();
      chk("proto_err_sync_end_idle", MW'(o_proto_err), 1);
      run_op({25'h0000123, 7'b1010111}, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("proto_err_sticky", MW'(o_proto_err), 1);
      apply_reset();
      tick();
      chk("proto_err_cleared", MW'(o_proto_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
